// File: rtl/fifo_prog.sv
// fifo_prog: single-clock synchronous FIFO with programmable almost-full /
// almost-empty thresholds, live fill count and one-cycle overflow/underflow
// pulses. Define FIFO_FWFT_EN to select first-word-fall-through reads;
// leaving it undefined selects the standard registered read port.
module fifo_prog #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wr_en,
    input  logic [WIDTH-1:0]           wr_data,
    output logic                       fifo_full,
    input  logic                       rd_en,
    output logic [WIDTH-1:0]           rd_data,
    output logic                       fifo_empty,
    input  logic [$clog2(DEPTH):0]     af_thresh,
    input  logic [$clog2(DEPTH):0]     ae_thresh,
    output logic                       almost_full,
    output logic                       almost_empty,
    output logic [$clog2(DEPTH):0]     fifo_count,
    output logic                       overflow,
    output logic                       underflow
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count_nxt_c;
    logic             wr_acc_c;
    logic             rd_acc_c;

    // Accept decisions look only at the registered flags
    assign wr_acc_c = wr_en && !fifo_full;
    assign rd_acc_c = rd_en && !fifo_empty;

    // Next occupancy; flags are derived from it so they line up with fifo_count
    always_comb begin
        count_nxt_c = fifo_count;
        if (wr_acc_c && !rd_acc_c) begin
            count_nxt_c = fifo_count + CW'(1);
        end else if (rd_acc_c && !wr_acc_c) begin
            count_nxt_c = fifo_count - CW'(1);
        end
    end

    // Pointers, count, status flags and error pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            fifo_count   <= '0;
            fifo_full    <= 1'b0;
            fifo_empty   <= 1'b1;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
        end else begin
            if (wr_acc_c) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd_acc_c) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            fifo_count   <= count_nxt_c;
            fifo_full    <= (count_nxt_c == CW'(DEPTH));
            fifo_empty   <= (count_nxt_c == '0);
            almost_full  <= (count_nxt_c >= af_thresh);
            almost_empty <= (count_nxt_c <= ae_thresh);
            overflow     <= wr_en && fifo_full;
            underflow    <= rd_en && fifo_empty;
        end
    end

    // Storage array; contents are intentionally not reset
    always_ff @(posedge clk) begin
        if (wr_acc_c) begin
            mem[wr_ptr] <= wr_data;
        end
    end

`ifdef FIFO_FWFT_EN
    // Head word falls through; zero while empty so reset reads back as 0
    assign rd_data = fifo_empty ? '0 : mem[rd_ptr];
`else
    // Registered read port; holds until the next accepted read
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else if (rd_acc_c) begin
            rd_data <= mem[rd_ptr];
        end
    end
`endif

endmodule

// File: tb/tb_fifo_prog.sv
// Directed self-checking bench for fifo_prog (WIDTH=16, DEPTH=32).
// Works in both read modes; FIFO_FWFT_EN selects the matching read checks.
module tb_fifo_prog;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wr_en;
    logic [15:0] wr_data;
    logic        fifo_full;
    logic        rd_en;
    logic [15:0] rd_data;
    logic        fifo_empty;
    logic [5:0]  af_thresh;
    logic [5:0]  ae_thresh;
    logic        almost_full;
    logic        almost_empty;
    logic [5:0]  fifo_count;
    logic        overflow;
    logic        underflow;

    int checks = 0;
    int errors = 0;
    logic [15:0] q[$];

    fifo_prog #(.WIDTH(16), .DEPTH(32)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .wr_en        (wr_en),
        .wr_data      (wr_data),
        .fifo_full    (fifo_full),
        .rd_en        (rd_en),
        .rd_data      (rd_data),
        .fifo_empty   (fifo_empty),
        .af_thresh    (af_thresh),
        .ae_thresh    (ae_thresh),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .fifo_count   (fifo_count),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL timeout CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input logic w, input logic r, input logic [15:0] d);
        wr_en = w; rd_en = r; wr_data = d;
        @(posedge clk);
        #1;
        wr_en = 1'b0; rd_en = 1'b0;
    endtask

    // One accepted read, checking the returned word in the active mode
    task automatic rd_word(input string tag, input logic [15:0] exp);
`ifdef FIFO_FWFT_EN
        chk(tag, rd_data, exp);
        cyc(1'b0, 1'b1, 16'h0);
`else
        cyc(1'b0, 1'b1, 16'h0);
        chk(tag, rd_data, exp);
`endif
    endtask

    // Simultaneous write d and read of expected word exp
    task automatic both(input string tag, input logic [15:0] d, input logic [15:0] exp);
`ifdef FIFO_FWFT_EN
        chk(tag, rd_data, exp);
        cyc(1'b1, 1'b1, d);
`else
        cyc(1'b1, 1'b1, d);
        chk(tag, rd_data, exp);
`endif
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_empty"}, fifo_empty, 1'b1);
        chk({tag, "_full"}, fifo_full, 1'b0);
        chk({tag, "_ae"}, almost_empty, 1'b1);
        chk({tag, "_af"}, almost_full, 1'b0);
        chk({tag, "_count"}, fifo_count, 6'd0);
        chk({tag, "_ovf"}, overflow, 1'b0);
        chk({tag, "_unf"}, underflow, 1'b0);
        chk({tag, "_rdata"}, rd_data, 16'h0);
    endtask

    initial begin
        rst_n = 1'b0; wr_en = 1'b0; rd_en = 1'b0; wr_data = '0;
        af_thresh = 6'd28; ae_thresh = 6'd3;
        #12;
        chk_reset_outputs("rst");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Fill with 0x0001..0x0020, checking flags at every level
        for (int i = 1; i <= 32; i++) begin
            cyc(1'b1, 1'b0, 16'(i));
            chk("fill_count", fifo_count, 32'(i));
            chk("fill_full", fifo_full, (i == 32));
            chk("fill_empty", fifo_empty, 1'b0);
            chk("fill_af", almost_full, (i >= 28));
            chk("fill_ae", almost_empty, (i <= 3));
        end

        // 33rd write is rejected with a single overflow pulse
        cyc(1'b1, 1'b0, 16'hBEEF);
        chk("ovf_pulse", overflow, 1'b1);
        chk("ovf_count", fifo_count, 6'd32);
        cyc(1'b0, 1'b0, 16'h0);
        chk("ovf_clear", overflow, 1'b0);

        // Drain in order
        for (int i = 1; i <= 32; i++) begin
            rd_word("drain_data", 16'(i));
            chk("drain_count", fifo_count, 32'(32 - i));
            chk("drain_ae", almost_empty, ((32 - i) <= 3));
            chk("drain_af", almost_full, ((32 - i) >= 28));
        end
        chk("drain_empty", fifo_empty, 1'b1);

        // Read while empty: one underflow pulse, nothing else changes
        cyc(1'b0, 1'b1, 16'h0);
        chk("unf_pulse", underflow, 1'b1);
        chk("unf_empty", fifo_empty, 1'b1);
        chk("unf_count", fifo_count, 6'd0);
`ifndef FIFO_FWFT_EN
        chk("unf_hold", rd_data, 16'h0020);
`endif
        cyc(1'b0, 1'b0, 16'h0);
        chk("unf_clear", underflow, 1'b0);

        // Fill 20 / read 20 to move pointers toward the wrap
        for (int i = 0; i < 20; i++) cyc(1'b1, 1'b0, 16'h0100 + 16'(i));
        chk("w20_count", fifo_count, 6'd20);
        for (int i = 0; i < 20; i++) rd_word("r20_data", 16'h0100 + 16'(i));
        chk("r20_count", fifo_count, 6'd0);

        // Prime 4 words then stream 40 simultaneous write/read cycles across the wrap
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, 1'b0, 16'h0200 + 16'(i));
            q.push_back(16'h0200 + 16'(i));
        end
        for (int i = 0; i < 40; i++) begin
            logic [15:0] d;
            logic [15:0] e;
            d = 16'h0300 + 16'(i);
            e = q.pop_front();
            q.push_back(d);
            both("sim_data", d, e);
            chk("sim_count", fifo_count, 6'd4);
        end
        while (q.size() > 0) rd_word("sim_drain", q.pop_front());
        chk("sim_empty", fifo_empty, 1'b1);

        // Threshold change at count 12
        for (int i = 0; i < 12; i++) cyc(1'b1, 1'b0, 16'h0400 + 16'(i));
        chk("th12_af", almost_full, 1'b0);
        chk("th12_ae", almost_empty, 1'b0);
        af_thresh = 6'd10;
        cyc(1'b0, 1'b0, 16'h0);
        chk("th10_af", almost_full, 1'b1);
        af_thresh = 6'd28;
        cyc(1'b0, 1'b0, 16'h0);
        chk("th28_af", almost_full, 1'b0);

        // Reset mid-stream at count 17 clears everything without a clock edge
        for (int i = 12; i < 17; i++) cyc(1'b1, 1'b0, 16'h0400 + 16'(i));
        chk("mid_count", fifo_count, 6'd17);
        #3;
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        cyc(1'b1, 1'b0, 16'h0AA5);
        rd_word("restart_data", 16'h0AA5);
        chk("restart_count", fifo_count, 6'd0);

        // Empty with both requests: write accepted, read rejected
        cyc(1'b1, 1'b1, 16'h0C00);
        chk("eboth_count", fifo_count, 6'd1);
        chk("eboth_unf", underflow, 1'b1);
        chk("eboth_ovf", overflow, 1'b0);
        chk("eboth_empty", fifo_empty, 1'b0);

        // Full with both requests: read accepted, write rejected
        for (int i = 1; i < 32; i++) cyc(1'b1, 1'b0, 16'h0C00 + 16'(i));
        chk("fboth_full_pre", fifo_full, 1'b1);
        both("fboth_data", 16'hDEAD, 16'h0C00);
        chk("fboth_count", fifo_count, 6'd31);
        chk("fboth_ovf", overflow, 1'b1);
        chk("fboth_unf", underflow, 1'b0);
        chk("fboth_full", fifo_full, 1'b0);
        chk("fboth_af", almost_full, 1'b1);
        for (int i = 1; i < 32; i++) rd_word("fboth_drain", 16'h0C00 + 16'(i));
        chk("fboth_empty", fifo_empty, 1'b1);

        // Write into a freshly reset FIFO with no read request
        rst_n = 1'b0;
        #1;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        cyc(1'b1, 1'b0, 16'h00AB);
`ifdef FIFO_FWFT_EN
        chk("fwft_data", rd_data, 16'h00AB);
`else
        chk("hold_data", rd_data, 16'h0000);
`endif
        chk("ab_count", fifo_count, 6'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
